// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: a 12-state Moore FSM that sequences
// fetch, decode and per-instruction execute/writeback steps, and produces
// the datapath enables, selects and the ALU operation code.
module multicycle_control #(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCEn,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] AluCon,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;

  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic       w_pcen;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [2:0] w_alucon;

  // State register; reset forces FETCH even mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the opcode in DECODE so later states ignore a changing IR input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 6'b000000;
    end else if (r_state == DECODE) begin
      r_op <= Op;
    end
  end

  // Next-state logic; DECODE dispatches on live Op, later states on r_op.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) begin
          w_next = MEMADR;
        end else if (Op == OP_RTYPE) begin
          w_next = EXEC;
        end else if (Op == OP_BEQ || (ENABLE_BNE && Op == OP_BNE)) begin
          w_next = BRANCH;
        end else if (Op == OP_ADDI) begin
          w_next = ADDIEX;
        end else if (Op == OP_J) begin
          w_next = JUMP;
        end else begin
          w_next = FETCH;
        end
      end
      MEMADR: w_next = (r_op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  w_next = MEMWB;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  // Moore outputs per state; PCEn alone also looks at Zero during BRANCH.
  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_pcen     = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_alucon   = ALU_ADD;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcen    = 1'b1;
      end
      DECODE: w_alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      MEMRD: w_iord = 1'b1;
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      EXEC: begin
        w_alusrca = 1'b1;
        case (Funct)
          6'b100000: w_alucon = ALU_ADD;
          6'b100010: w_alucon = ALU_SUB;
          6'b100100: w_alucon = ALU_AND;
          6'b100101: w_alucon = ALU_OR;
          6'b101010: w_alucon = ALU_SLT;
          default:   w_alucon = ALU_ADD;
        endcase
      end
      ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      BRANCH: begin
        w_alusrca = 1'b1;
        w_alucon  = ALU_SUB;
        w_pcsrc   = 2'b01;
        w_pcen    = (r_op == OP_BNE) ? ~Zero : Zero;
      end
      ADDIWB: w_regwrite = 1'b1;
      JUMP: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed while reset is held; state is FETCH then.
  assign IRWrite  = w_irwrite & rst_n;
  assign PCEn     = w_pcen & rst_n;
  assign MemWrite = w_memwrite & rst_n;
  assign RegWrite = w_regwrite & rst_n;
  assign IorD     = w_iord;
  assign RegDst   = w_regdst;
  assign MemtoReg = w_memtoreg;
  assign ALUSrcA  = w_alusrca;
  assign ALUSrcB  = w_alusrcb;
  assign PCSrc    = w_pcsrc;
  assign AluCon   = w_alucon;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM and checks states and control outputs at each step.
// A second instance with ENABLE_BNE=0 checks that bne is treated as illegal.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;

  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] AluCon;
  logic [3:0] state;

  logic       nb_IorD, nb_MemWrite, nb_IRWrite, nb_RegDst, nb_MemtoReg, nb_RegWrite;
  logic       nb_ALUSrcA, nb_PCEn;
  logic [1:0] nb_ALUSrcB, nb_PCSrc;
  logic [2:0] nb_AluCon;
  logic [3:0] nb_state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCEn(PCEn),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .AluCon(AluCon), .state(state)
  );

  multicycle_control #(.ENABLE_BNE(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(nb_IorD), .MemWrite(nb_MemWrite), .IRWrite(nb_IRWrite), .RegDst(nb_RegDst),
    .MemtoReg(nb_MemtoReg), .RegWrite(nb_RegWrite), .ALUSrcA(nb_ALUSrcA), .PCEn(nb_PCEn),
    .ALUSrcB(nb_ALUSrcB), .PCSrc(nb_PCSrc), .AluCon(nb_AluCon), .state(nb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Op    = 6'b100011;
    Funct = 6'b000000;
    Zero  = 1'b0;
    #2;
    // Reset: FETCH selects, write enables held low
    chk("rst_state",    {4'b0, state},    8'd0);
    chk("rst_irwrite",  {7'b0, IRWrite},  8'd0);
    chk("rst_pcen",     {7'b0, PCEn},     8'd0);
    chk("rst_regwrite", {7'b0, RegWrite}, 8'd0);
    chk("rst_memwrite", {7'b0, MemWrite}, 8'd0);
    chk("rst_alusrcb",  {6'b0, ALUSrcB},  8'h01);
    chk("rst_alucon",   {5'b0, AluCon},   8'h02);
    tick();
    chk("rst_hold_state", {4'b0, state}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fetch_irwrite", {7'b0, IRWrite}, 8'd1);
    chk("fetch_pcen",    {7'b0, PCEn},    8'd1);

    // lw: 0,1,2,3,4,0
    tick();
    chk("lw_s1",        {4'b0, state},   8'd1);
    chk("dec_alusrcb",  {6'b0, ALUSrcB}, 8'h03);
    chk("dec_irwrite",  {7'b0, IRWrite}, 8'd0);
    tick();
    chk("lw_s2",        {4'b0, state},   8'd2);
    chk("memadr_srca",  {7'b0, ALUSrcA}, 8'd1);
    chk("memadr_srcb",  {6'b0, ALUSrcB}, 8'h02);
    tick();
    chk("lw_s3",        {4'b0, state},    8'd3);
    chk("memrd_iord",   {7'b0, IorD},     8'd1);
    chk("memrd_regwr",  {7'b0, RegWrite}, 8'd0);
    tick();
    chk("lw_s4",        {4'b0, state},    8'd4);
    chk("memwb_regwr",  {7'b0, RegWrite}, 8'd1);
    chk("memwb_m2r",    {7'b0, MemtoReg}, 8'd1);
    tick();
    chk("lw_s0",        {4'b0, state},    8'd0);
    chk("lw_end_regwr", {7'b0, RegWrite}, 8'd0);

    // R-type sub
    Op = 6'b000000; Funct = 6'b100010;
    tick(); tick();
    chk("rt_sub_s6",    {4'b0, state},   8'd6);
    chk("rt_sub_alu",   {5'b0, AluCon},  8'h06);
    chk("rt_srcb",      {6'b0, ALUSrcB}, 8'h00);
    tick();
    chk("rt_s7",        {4'b0, state},    8'd7);
    chk("rt_regdst",    {7'b0, RegDst},   8'd1);
    chk("rt_regwr",     {7'b0, RegWrite}, 8'd1);
    tick();
    chk("rt_s0",        {4'b0, state},    8'd0);
    // R-type slt
    Funct = 6'b101010;
    tick(); tick();
    chk("rt_slt_alu",   {5'b0, AluCon},  8'h07);
    tick(); tick();
    // R-type unknown funct defaults to add and still writes back
    Funct = 6'b111111;
    tick(); tick();
    chk("rt_unk_alu",   {5'b0, AluCon},  8'h02);
    tick();
    chk("rt_unk_regwr", {7'b0, RegWrite}, 8'd1);
    tick();

    // beq
    Op = 6'b000100; Zero = 1'b1;
    tick(); tick();
    chk("beq_s8",       {4'b0, state},  8'd8);
    chk("beq_z1_pcen",  {7'b0, PCEn},   8'd1);
    chk("beq_pcsrc",    {6'b0, PCSrc},  8'h01);
    chk("beq_alucon",   {5'b0, AluCon}, 8'h06);
    Zero = 1'b0;
    #1;
    chk("beq_z0_pcen",  {7'b0, PCEn},   8'd0);
    tick();
    chk("beq_s0",       {4'b0, state},  8'd0);

    // bne: inverted on the default instance, illegal when disabled
    Op = 6'b000101; Zero = 1'b1;
    tick();
    chk("nb_s1",        {4'b0, nb_state}, 8'd1);
    tick();
    chk("bne_s8",       {4'b0, state},    8'd8);
    chk("bne_z1_pcen",  {7'b0, PCEn},     8'd0);
    chk("nb_bne_fetch", {4'b0, nb_state}, 8'd0);
    Zero = 1'b0;
    #1;
    chk("bne_z0_pcen",  {7'b0, PCEn},     8'd1);
    tick();
    chk("bne_s0",       {4'b0, state},    8'd0);

    // sw with Op changing during MEMADR
    Op = 6'b101011;
    tick(); tick();
    chk("sw_s2",        {4'b0, state}, 8'd2);
    Op = 6'b100011;
    tick();
    chk("sw_s5",        {4'b0, state},    8'd5);
    chk("sw_memwr",     {7'b0, MemWrite}, 8'd1);
    chk("sw_iord",      {7'b0, IorD},     8'd1);
    tick();
    chk("sw_s0",        {4'b0, state}, 8'd0);

    // j
    Op = 6'b000010;
    tick(); tick();
    chk("j_s11",        {4'b0, state}, 8'd11);
    chk("j_pcen",       {7'b0, PCEn},  8'd1);
    chk("j_pcsrc",      {6'b0, PCSrc}, 8'h02);
    tick();
    chk("j_s0",         {4'b0, state}, 8'd0);

    // addi
    Op = 6'b001000;
    tick(); tick();
    chk("addi_s9",      {4'b0, state},   8'd9);
    chk("addi_srcb",    {6'b0, ALUSrcB}, 8'h02);
    tick();
    chk("addi_s10",     {4'b0, state},    8'd10);
    chk("addi_regwr",   {7'b0, RegWrite}, 8'd1);
    chk("addi_regdst",  {7'b0, RegDst},   8'd0);
    tick();

    // illegal opcode: 0,1,0 with no writes in DECODE
    Op = 6'b111111;
    tick();
    chk("ill_s1",       {4'b0, state},    8'd1);
    chk("ill_regwr",    {7'b0, RegWrite}, 8'd0);
    chk("ill_memwr",    {7'b0, MemWrite}, 8'd0);
    chk("ill_pcen",     {7'b0, PCEn},     8'd0);
    tick();
    chk("ill_s0",       {4'b0, state}, 8'd0);

    // reset asserted in MEMRD
    Op = 6'b100011;
    tick(); tick(); tick();
    chk("mr_s3",        {4'b0, state}, 8'd3);
    rst_n = 1'b0;
    #1;
    chk("mr_state",     {4'b0, state},    8'd0);
    chk("mr_regwr",     {7'b0, RegWrite}, 8'd0);
    tick();
    chk("mr_hold_regwr", {7'b0, RegWrite}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_fetch_ir",  {7'b0, IRWrite}, 8'd1);
    chk("mr_fetch_pc",  {7'b0, PCEn},    8'd1);
    tick();
    chk("mr_decode",    {4'b0, state}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
